// File: rtl/spi_temp_reader.sv
// spi_temp_reader: free-running SPI mode-0 master (MSB first, read-only) that
// polls a serial temperature sensor every PERIOD clocks and publishes an
// 8-bit temperature word plus the sensor fault flag.
//
// Optional feature: define TEMP_AVG_EN to publish the floor of the mean of
// the last four non-fault samples instead of the latest non-fault sample.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset; leaves as soon as the period counter is 0
// CS_SETUP | cs_n low, sck low for CLK_DIV cycles before the first bit
// SHIFT    | FRAME_BITS bits, each CLK_DIV cycles sck low then high
// CS_HOLD  | cs_n low, sck low for CLK_DIV cycles after the last bit
// PUBLISH  | one cycle, cs_n high, temp_valid pulse, outputs updated
// WAIT     | cs_n high until the period counter reaches 0
module spi_temp_reader #(
   parameter int CLK_DIV    = 25,
   parameter int FRAME_BITS = 16,
   parameter int DATA_LSB   = 5,
   parameter int FAULT_BIT  = 2,
   parameter int PERIOD     = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       miso,
   output logic       sck,
   output logic       cs_n,
   output logic [7:0] temp_out,
   output logic       temp_valid,
   output logic       sensor_fault,
   output logic       busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(FRAME_BITS);
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   // Only the frame bits up to the highest one we use are kept; earlier
   // bits fall off the top of the shift register.
   localparam int SW = (DATA_LSB + 8 > FAULT_BIT + 1) ? DATA_LSB + 8 : FAULT_BIT + 1;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      PUBLISH,
      WAIT
   } state_t;

   state_t          state_q, state_n;
   logic [DW-1:0]   div_q, div_n;
   logic [BW-1:0]   bit_q, bit_n;
   logic [PW-1:0]   period_q, period_n;
   logic            sck_q, sck_n;
   logic            cs_n_q, cs_n_n;
   logic            shift_en;
   logic            publish_en;
   logic            miso_m, miso_s;
   logic [SW-1:0]   shreg_q;
   logic [7:0]      sample;
   logic            frame_fault;
   logic [7:0]      temp_next;

   assign sample      = shreg_q[DATA_LSB +: 8];
   assign frame_fault = shreg_q[FAULT_BIT];
   assign sck         = sck_q;
   assign cs_n        = cs_n_q;
   assign busy        = ~cs_n_q;

   // Two-flop synchronizer for the sensor data line.
   always_ff @(posedge clock) begin
      if (!reset) begin
         miso_m <= 1'b0;
         miso_s <= 1'b0;
      end else begin
         miso_m <= miso;
         miso_s <= miso_m;
      end
   end

   // State, timers and the registered sck / cs_n pins.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         period_q <= '0;
         sck_q    <= 1'b0;
         cs_n_q   <= 1'b1;
      end else begin
         state_q  <= state_n;
         div_q    <= div_n;
         bit_q    <= bit_n;
         period_q <= period_n;
         sck_q    <= sck_n;
         cs_n_q   <= cs_n_n;
      end
   end

   // Next-state, timer reloads and strobes for shifting and publishing.
   always_comb begin
      state_n    = state_q;
      div_n      = div_q;
      bit_n      = bit_q;
      sck_n      = sck_q;
      period_n   = (period_q != '0) ? period_q - PW'(1) : period_q;
      shift_en   = 1'b0;
      publish_en = 1'b0;

      case (state_q)
         IDLE, WAIT: begin
            sck_n = 1'b0;
            if (period_q == '0) begin
               state_n  = CS_SETUP;
               div_n    = DW'(CLK_DIV - 1);
               period_n = PW'(PERIOD - 1);
            end
         end
         CS_SETUP: begin
            if (div_q == '0) begin
               state_n = SHIFT;
               div_n   = DW'(CLK_DIV - 1);
               bit_n   = BW'(FRAME_BITS - 1);
            end else begin
               div_n = div_q - DW'(1);
            end
         end
         SHIFT: begin
            if (div_q == '0) begin
               div_n = DW'(CLK_DIV - 1);
               if (!sck_q) begin
                  sck_n    = 1'b1;
                  shift_en = 1'b1;
               end else begin
                  sck_n = 1'b0;
                  if (bit_q == '0) begin
                     state_n = CS_HOLD;
                  end else begin
                     bit_n = bit_q - BW'(1);
                  end
               end
            end else begin
               div_n = div_q - DW'(1);
            end
         end
         CS_HOLD: begin
            if (div_q == '0) begin
               state_n    = PUBLISH;
               publish_en = 1'b1;
            end else begin
               div_n = div_q - DW'(1);
            end
         end
         PUBLISH: begin
            state_n = WAIT;
         end
         default: begin
            state_n = IDLE;
            sck_n   = 1'b0;
         end
      endcase

      cs_n_n = !((state_n == CS_SETUP) || (state_n == SHIFT) || (state_n == CS_HOLD));
   end

`ifdef TEMP_AVG_EN
   // Three previous good samples; the fourth term of the average is the
   // sample being published, so no fourth register is needed.
   logic [2:0][7:0] hist_q;
   logic            hist_full_q;
   logic [2:0][7:0] hist_n;
   logic [9:0]      hist_sum;

   // Window seen by this publish: seeded from the sample on the first good frame.
   always_comb begin
      hist_n    = hist_full_q ? hist_q : {3{sample}};
      hist_sum  = 10'(sample) + 10'(hist_n[0]) + 10'(hist_n[1]) + 10'(hist_n[2]);
      temp_next = hist_sum[9:2];
   end

   // Slide the history on every good frame; fault frames leave it untouched.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hist_q      <= '0;
         hist_full_q <= 1'b0;
      end else if (publish_en && !frame_fault) begin
         hist_q      <= {hist_n[1:0], sample};
         hist_full_q <= 1'b1;
      end
   end
`else
   // Without averaging the published value is simply the latest sample.
   always_comb temp_next = sample;
`endif

   // Frame capture and the published outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         shreg_q      <= '0;
         temp_out     <= '0;
         temp_valid   <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         if (shift_en) begin
            shreg_q <= {shreg_q[SW-2:0], miso_s};
         end
         temp_valid <= publish_en;
         if (publish_en) begin
            sensor_fault <= frame_fault;
            if (!frame_fault) begin
               temp_out <= temp_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_temp_reader.sv
// Bench for spi_temp_reader: two instances (PERIOD=200 and PERIOD=100), each
// with a behavioural SPI slave fed from a word queue, plus a scoreboard of
// expected {temp, fault} results popped on every temp_valid pulse.
module tb_spi_temp_reader;

   logic       clock = 1'b0;
   logic       reset_a, reset_b;
   logic       miso_a = 1'b0, miso_b = 1'b0;
   logic       sck_a, cs_n_a, tv_a, fault_a, busy_a;
   logic       sck_b, cs_n_b, tv_b, fault_b, busy_b;
   logic [7:0] temp_a, temp_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [8:0]  a_exp_q[$];
   logic [8:0]  b_exp_q[$];
   logic [15:0] a_slave_q[$];
   logic [15:0] b_slave_q[$];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   spi_temp_reader #(
      .CLK_DIV(4), .FRAME_BITS(16), .DATA_LSB(5), .FAULT_BIT(2), .PERIOD(200)
   ) dut_a (
      .clock(clock), .reset(reset_a), .miso(miso_a), .sck(sck_a), .cs_n(cs_n_a),
      .temp_out(temp_a), .temp_valid(tv_a), .sensor_fault(fault_a), .busy(busy_a)
   );

   spi_temp_reader #(
      .CLK_DIV(4), .FRAME_BITS(16), .DATA_LSB(5), .FAULT_BIT(2), .PERIOD(100)
   ) dut_b (
      .clock(clock), .reset(reset_b), .miso(miso_b), .sck(sck_b), .cs_n(cs_n_b),
      .temp_out(temp_b), .temp_valid(tv_b), .sensor_fault(fault_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Registered copy of reset_a so the monitor sees a reset without racing the stimulus.
   logic a_rst_q = 1'b0;
   always @(posedge clock) a_rst_q <= reset_a;

   // Slave models, invariants and scoreboard, all sampled on the falling clock edge.
   logic [15:0] a_word = 16'hFFFF, b_word = 16'hFFFF;
   logic [8:0]  e;
   logic [7:0]  a_last = 8'h00, b_last = 8'h00;
   logic        cs_prev_a = 1'b1, cs_prev_b = 1'b1;
   logic        sck_prev_a = 1'b0, sck_prev_b = 1'b0;
   logic        tv_prev_a = 1'b0, tv_prev_b = 1'b0;
   logic        b_started = 1'b0;
   int          a_rises = 0, b_rises = 0, b_high = 0;

   always @(negedge clock) begin
      if (!a_rst_q) a_last = 8'h00;

      check("a_busy", busy_a, !cs_n_a);
      check("a_sck_quiet", sck_a && cs_n_a, 0);
      check("a_valid_single", tv_a && tv_prev_a, 0);
      check("b_busy", busy_b, !cs_n_b);
      check("b_sck_quiet", sck_b && cs_n_b, 0);
      check("b_valid_single", tv_b && tv_prev_b, 0);

      if (tv_a) begin
         if (a_exp_q.size() > 0) begin
            e = a_exp_q.pop_front();
            check("a_temp", temp_a, e[8:1]);
            check("a_fault", fault_a, e[0]);
            a_last = e[8:1];
         end else begin
            check("a_idle_temp", temp_a, a_last);
            check("a_idle_fault", fault_a, 1);
         end
         check("a_sck_rises", a_rises, 16);
      end
      if (tv_b) begin
         if (b_exp_q.size() > 0) begin
            e = b_exp_q.pop_front();
            check("b_temp", temp_b, e[8:1]);
            check("b_fault", fault_b, e[0]);
            b_last = e[8:1];
         end else begin
            check("b_idle_temp", temp_b, b_last);
            check("b_idle_fault", fault_b, 1);
         end
         check("b_sck_rises", b_rises, 16);
      end

      // Slave A: MSB out on cs_n fall, next bit after each sck fall.
      if (!cs_n_a && cs_prev_a) begin
         a_word  = (a_slave_q.size() > 0) ? a_slave_q.pop_front() : 16'hFFFF;
         miso_a  = a_word[15];
         a_rises = 0;
      end else if (!cs_n_a && sck_prev_a && !sck_a) begin
         a_word = a_word << 1;
         miso_a = a_word[15];
      end
      if (!cs_n_a && sck_a && !sck_prev_a) a_rises++;

      // Slave B, plus the cs_n high gap between frames.
      if (!cs_n_b && cs_prev_b) begin
         if (b_started) check("b_cs_high_gap", b_high, 2);
         b_started = 1'b1;
         b_high    = 0;
         b_word    = (b_slave_q.size() > 0) ? b_slave_q.pop_front() : 16'hFFFF;
         miso_b    = b_word[15];
         b_rises   = 0;
      end else if (!cs_n_b && sck_prev_b && !sck_b) begin
         b_word = b_word << 1;
         miso_b = b_word[15];
      end else if (cs_n_b) begin
         b_high++;
      end
      if (!cs_n_b && sck_b && !sck_prev_b) b_rises++;

      cs_prev_a  = cs_n_a;
      cs_prev_b  = cs_n_b;
      sck_prev_a = sck_a;
      sck_prev_b = sck_b;
      tv_prev_a  = tv_a;
      tv_prev_b  = tv_b;
   end

   // Directed stimulus and timing measurements.
   initial begin
      int   n;
      int   t0;
      int   rises;
      logic prev;

      reset_a = 1'b0;
      reset_b = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_cs_n", cs_n_a, 1);
      check("rst_sck", sck_a, 0);
      check("rst_temp", temp_a, 0);
      check("rst_valid", tv_a, 0);
      check("rst_fault", fault_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_b_cs_n", cs_n_b, 1);

      // A: good frame (100), fault frame, then a frame that will be aborted.
      a_slave_q.push_back(16'h0C80);
      a_slave_q.push_back(16'h0C84);
      a_slave_q.push_back(16'h0C80);
      a_slave_q.push_back(16'h1020);
      a_slave_q.push_back(16'h0004);
      a_exp_q.push_back({8'h64, 1'b0});
      a_exp_q.push_back({8'h64, 1'b1});

      // B: 100,100,100,104 then a fault frame.
      b_slave_q.push_back(16'h0C80);
      b_slave_q.push_back(16'h0C80);
      b_slave_q.push_back(16'h0C80);
      b_slave_q.push_back(16'h0D00);
      b_slave_q.push_back(16'h0C84);
      b_exp_q.push_back({8'd100, 1'b0});
      b_exp_q.push_back({8'd100, 1'b0});
      b_exp_q.push_back({8'd100, 1'b0});
`ifdef TEMP_AVG_EN
      b_exp_q.push_back({8'd101, 1'b0});
      b_exp_q.push_back({8'd101, 1'b1});
`else
      b_exp_q.push_back({8'd104, 1'b0});
      b_exp_q.push_back({8'd104, 1'b1});
`endif

      reset_a = 1'b1;
      reset_b = 1'b1;

      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cs_n_a && n < 20);
      check("cs_fall_latency", n, 1);
      t0 = cyc;

      n = 0;
      while (!sck_a && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("first_sck_rise", n, 8);

      while (!cs_n_a && cyc - t0 < 400) @(negedge clock);
      check("cs_low_time", cyc - t0, 136);
      while (cs_n_a && cyc - t0 < 400) @(negedge clock);
      check("cs_fall_period", cyc - t0, 200);

      // Let frame 2 finish, then abort frame 3 after its eighth sck rise.
      t0 = cyc;
      while (!cs_n_a && cyc - t0 < 400) @(negedge clock);
      while (cs_n_a && cyc - t0 < 400) @(negedge clock);
      check("frame3_start", cs_n_a, 0);
      rises = 0;
      prev  = sck_a;
      n     = 0;
      while (rises < 8 && n < 200) begin
         @(negedge clock);
         n++;
         if (sck_a && !prev) rises++;
         prev = sck_a;
      end
      check("abort_point", rises, 8);

      reset_a = 1'b0;
      @(negedge clock);
      check("abort_cs_n", cs_n_a, 1);
      check("abort_sck", sck_a, 0);
      check("abort_temp", temp_a, 0);
      check("abort_valid", tv_a, 0);
      check("abort_fault", fault_a, 0);
      check("abort_busy", busy_a, 0);
      a_exp_q.push_back({8'h81, 1'b0});
      a_exp_q.push_back({8'h81, 1'b1});
      reset_a = 1'b1;

      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cs_n_a && n < 20);
      check("cs_fall_after_abort", n, 1);

      n = 0;
      while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check("a_drained", a_exp_q.size(), 0);
      check("b_drained", b_exp_q.size(), 0);
      repeat (10) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_temp_reader.md
Name: spi_temp_reader

Overview:
- SPI master that periodically reads a serial temperature sensor (mode 0, MSB first, read-only) and presents an 8-bit temperature word plus status to the processor's parallel input pins (in0..in7).
- Sits directly upstream of the top-level wrapper: temp_out[0] drives in0 through temp_out[7] driving in7.
- Owns the sensor's chip select and bit clock.
- Free-runs: no processor request is needed.

Parameters:
- CLK_DIV, 25: system clocks per SCK half-period; must be >= 3.
- FRAME_BITS, 16: bits shifted per conversion; 8..32.
- DATA_LSB, 5: frame bit index of temperature LSB; temperature is frame[DATA_LSB+7:DATA_LSB]; DATA_LSB+7 < FRAME_BITS.
- FAULT_BIT, 2: frame bit index of the sensor's open/fault flag.
- PERIOD, 1000000: system clocks between successive cs_n falling edges.

Ports:
- clock, in, 1: system clock; all logic on rising edge.
- reset, in, 1: synchronous, active-low reset.
- miso, in, 1: sensor serial data; asynchronous to clock.
- sck, out, 1: sensor bit clock.
- cs_n, out, 1: sensor chip select, active low.
- temp_out, out, 8: last good temperature; bit i drives processor in_i.
- temp_valid, out, 1: one-cycle pulse when a frame completes.
- sensor_fault, out, 1: FAULT_BIT of the last completed frame.
- busy, out, 1: high while cs_n is low.

Behaviour:
- Reset: clock and reset are single-clock; reset is synchronous and active-low.
  - While reset=0 at a rising edge: sck=0, cs_n=1, temp_out=0, temp_valid=0, sensor_fault=0, busy=0, state=IDLE, counters=0.
  - Reset asserted mid-frame aborts immediately with the same values; no partial frame is published.
- miso passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- States and transitions:
  - IDLE: period counter at 0 -> CS_SETUP. The first cycle after reset release is IDLE with counter 0, so cs_n falls one cycle after reset deasserts.
  - CS_SETUP: cs_n=0, sck=0 for CLK_DIV cycles -> SHIFT.
  - SHIFT: per bit, sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles.
    - Synchronized miso is shifted in (MSB first) on the cycle sck goes 0->1.
    - After FRAME_BITS bits, sck returns to 0 -> CS_HOLD.
  - CS_HOLD: cs_n=0, sck=0 for CLK_DIV cycles -> PUBLISH.
  - PUBLISH: lasts 1 cycle -> WAIT.
    - cs_n=1, temp_valid=1, sensor_fault=frame[FAULT_BIT].
    - temp_out updates only if the fault bit is 0; otherwise it holds its previous value.
  - WAIT: cs_n=1 until the period counter expires -> CS_SETUP.
- Timing:
  - cs_n low time = CLK_DIV*(2*FRAME_BITS+2) cycles.
  - busy equals ~cs_n.
- Period counter:
  - Loads PERIOD-1 on every cs_n falling edge and decrements to 0.
  - If PERIOD <= frame length+1, the next CS_SETUP follows PUBLISH by exactly one WAIT cycle, so cs_n is high for at least 2 cycles.
- sck never toggles while cs_n=1.
- temp_valid is never asserted two consecutive cycles.
- Counter widths are $clog2 of their maxima; no wrap is reachable in legal operation.

Optional Feature:
- Macro: TEMP_AVG_EN.
- Defined:
  - temp_out = floor(sum of the last 4 non-fault samples / 4), computed with a 10-bit sum.
  - The first non-fault sample after reset fills all 4 history slots.
  - Fault frames do not enter the history.
  - temp_out updates in the PUBLISH cycle.
- Not defined: temp_out = the latest non-fault sample; no history registers.

Test Plan:
(Parameters: CLK_DIV=4, FRAME_BITS=16, PERIOD=200.)
- Reset release -> cs_n falls 1 cycle later; first sck rise 8 cycles after cs_n falls; cs_n low exactly 136 cycles; next cs_n fall 200 cycles after the first.
- Slave returns 0x0C80 -> PUBLISH: temp_valid one pulse, temp_out=0x64, sensor_fault=0, exactly 16 sck rising edges.
- Slave returns 0x0C80, then 0x0C84 -> second frame: sensor_fault=1, temp_out stays 0x64, temp_valid still pulses.
- reset=0 held 1 cycle at bit 7 of a frame -> next cycle cs_n=1, sck=0, temp_out=0, no temp_valid; new frame starts cleanly after release.
- PERIOD=100 (shorter than the frame) -> cs_n high exactly 2 cycles between frames; no overlap.
- TEMP_AVG_EN defined, samples 100,100,100,104 -> temp_out 100,100,100,101; then a fault frame -> temp_out stays 101.
